// File: rtl/uart_tx_frame_gen.sv
// uart_tx_frame_gen
//   UART transmitter with a runtime-programmable bit period, 5..8 data bits,
//   optional even/odd parity and one or two stop bits. A frame request is
//   accepted only while idle; data and framing configuration are captured at
//   the acceptance edge, so upstream logic may change them freely afterwards.
//
// Ports
//   clk         system clock
//   rst         asynchronous, active-low reset
//   tx_start    frame request, sampled only while busy = 0
//   tx_data     payload byte, sent LSB first (bits above the data length ignored)
//   div_cfg     clock cycles per bit; 0 selects DEF_DIV, small values clamp to MIN_DIV
//   data_bits   00=5, 01=6, 10=7, 11=8 data bits
//   parity_en   append a parity bit
//   parity_odd  0 = even parity, 1 = odd parity
//   stop2       0 = one stop bit, 1 = two stop bits
//   tx          serial line, idle high, driven straight from a flop
//   busy        high from the acceptance edge until the frame ends
//   done        one-cycle pulse when the final stop bit completes
//   bit_idx     current frame bit: 0=start, 1..N=data, then parity, then stop(s)
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | line high, bit timer held at 0, waiting for tx_start
// S_START  | driving the start bit (tx=0)
// S_DATA   | shifting out data bits LSB first
// S_PARITY | driving the precomputed parity bit
// S_STOP   | driving stop bit(s); the last one returns to S_IDLE

module uart_tx_frame_gen #(
   parameter int DIV_W   = 16,
   parameter int DEF_DIV = 5208,
   parameter int MIN_DIV = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             tx_start,
   input  logic [7:0]       tx_data,
   input  logic [DIV_W-1:0] div_cfg,
   input  logic [1:0]       data_bits,
   input  logic             parity_en,
   input  logic             parity_odd,
   input  logic             stop2,
   output logic             tx,
   output logic             busy,
   output logic             done,
   output logic [3:0]       bit_idx
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   state_t           state;
   logic [DIV_W-1:0] div_eff;
   logic [DIV_W-1:0] div_q;
   logic [DIV_W-1:0] cnt;
   logic [7:0]       data_mask;
   logic [7:0]       shift_q;
   logic             par_in;
   logic             par_q;
   logic             par_en_q;
   logic [3:0]       last_data_idx;
   logic [3:0]       last_idx;
   logic [3:0]       last_data_q;
   logic [3:0]       last_q;
   logic             bit_end;

   // Effective divisor and frame shape, evaluated from the live inputs and
   // only captured at the acceptance edge.
   always_comb begin
      div_eff = div_cfg;
      if (div_cfg == '0) begin
         div_eff = DIV_W'(DEF_DIV);
      end else if (div_cfg < DIV_W'(MIN_DIV)) begin
         div_eff = DIV_W'(MIN_DIV);
      end

      data_mask = 8'hFF;
      case (data_bits)
         2'b00:   data_mask = 8'h1F;
         2'b01:   data_mask = 8'h3F;
         2'b10:   data_mask = 8'h7F;
         default: data_mask = 8'hFF;
      endcase

      par_in        = (^(tx_data & data_mask)) ^ parity_odd;
      last_data_idx = 4'd5 + {2'b00, data_bits};
      last_idx      = last_data_idx + {3'b000, parity_en} + 4'd1 + {3'b000, stop2};
   end

   // Bit boundary: the counter has spent div_q cycles in the current bit.
   assign bit_end = (cnt == (div_q - DIV_W'(1)));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= S_IDLE;
         tx          <= 1'b1;
         busy        <= 1'b0;
         done        <= 1'b0;
         bit_idx     <= 4'd0;
         cnt         <= '0;
         div_q       <= '0;
         shift_q     <= 8'h00;
         par_q       <= 1'b0;
         par_en_q    <= 1'b0;
         last_data_q <= 4'd0;
         last_q      <= 4'd0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               cnt <= '0;
               if (tx_start) begin
                  div_q       <= div_eff;
                  shift_q     <= tx_data;
                  par_q       <= par_in;
                  par_en_q    <= parity_en;
                  last_data_q <= last_data_idx;
                  last_q      <= last_idx;
                  state       <= S_START;
                  tx          <= 1'b0;
                  busy        <= 1'b1;
                  bit_idx     <= 4'd0;
               end
            end

            S_START, S_DATA, S_PARITY, S_STOP: begin
               if (!bit_end) begin
                  cnt <= cnt + DIV_W'(1);
               end else begin
                  cnt     <= '0;
                  bit_idx <= bit_idx + 4'd1;
                  case (state)
                     S_START: begin
                        state   <= S_DATA;
                        tx      <= shift_q[0];
                        shift_q <= shift_q >> 1;
                     end
                     S_DATA: begin
                        if (bit_idx != last_data_q) begin
                           tx      <= shift_q[0];
                           shift_q <= shift_q >> 1;
                        end else if (par_en_q) begin
                           state <= S_PARITY;
                           tx    <= par_q;
                        end else begin
                           state <= S_STOP;
                           tx    <= 1'b1;
                        end
                     end
                     S_PARITY: begin
                        state <= S_STOP;
                        tx    <= 1'b1;
                     end
                     default: begin
                        tx <= 1'b1;
                        if (bit_idx == last_q) begin
                           state   <= S_IDLE;
                           busy    <= 1'b0;
                           done    <= 1'b1;
                           bit_idx <= 4'd0;
                        end
                     end
                  endcase
               end
            end

            default: begin
               state <= S_IDLE;
               tx    <= 1'b1;
               busy  <= 1'b0;
               cnt   <= '0;
            end
         endcase
      end
   end

endmodule
